// File: rtl/spike_dec_pkg.sv
// Shared types, default widths and helpers for the spike rate decoder.
package spike_dec_pkg;

    localparam int unsigned WINDOW_LOG2_DEF = 8;
    localparam int unsigned RATE_W_DEF      = 8;
    localparam int unsigned ISI_W_DEF       = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Increment that sticks at max_val; callers zero-extend operands of up to 32 bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_isi_timer.sv
// Inter-spike interval timer: measures cycles between consecutive spike edges.
module isi_timer
    import spike_dec_pkg::*;
#(
    parameter int unsigned ISI_W = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             spike_edge,
    output logic [ISI_W-1:0] isi,
    output logic             isi_valid,
    output logic             isi_overflow
);

    localparam logic [ISI_W-1:0] ISI_ALL_ONES = '1;
    localparam logic [31:0]      ISI_MAX      = 32'(ISI_ALL_ONES);
    localparam logic [ISI_W-1:0] TIMER_ONE    = ISI_W'(1);

    logic [ISI_W-1:0] timer;
    logic             armed;

    // Timer restarts at 1 on each edge; edges after the arming edge capture the interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer        <= '0;
            armed        <= 1'b0;
            isi          <= '0;
            isi_valid    <= 1'b0;
            isi_overflow <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (!active) begin
                timer <= '0;
                armed <= 1'b0;
            end else if (spike_edge) begin
                timer <= TIMER_ONE;
                armed <= 1'b1;
                if (armed) begin
                    isi       <= timer;
                    isi_valid <= 1'b1;
                    if (timer == ISI_ALL_ONES) begin
                        isi_overflow <= 1'b1;
                    end
                end
            end else begin
                timer <= ISI_W'(sat_inc(32'(timer), ISI_MAX));
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: windowed spike-edge rate plus inter-spike interval.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = WINDOW_LOG2_DEF,
    parameter int unsigned RATE_W      = RATE_W_DEF,
    parameter int unsigned ISI_W       = ISI_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              spike_in,
    output logic [RATE_W-1:0] rate,
    output logic              rate_valid,
    output logic [ISI_W-1:0]  isi,
    output logic              isi_valid,
    output logic              isi_overflow,
    output logic              busy
);

    localparam logic [WINDOW_LOG2-1:0] WIN_LAST      = '1;
    localparam logic [WINDOW_LOG2-1:0] WIN_ONE       = WINDOW_LOG2'(1);
    localparam logic [RATE_W-1:0]      RATE_ALL_ONES = '1;
    localparam logic [31:0]            RATE_MAX      = 32'(RATE_ALL_ONES);

    state_t                 state;
    state_t                 state_d;
    logic                   busy_d;
    logic                   spike_q;
    logic                   edge_c;
    logic                   count_active_c;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [RATE_W-1:0]      edge_cnt;
    logic [RATE_W-1:0]      edge_cnt_inc_c;

    // Rising edge of the spike line; a sustained high level counts once.
    assign edge_c         = spike_in & ~spike_q;
    assign count_active_c = (state == COUNT) && en;
    assign edge_cnt_inc_c = edge_c ? RATE_W'(sat_inc(32'(edge_cnt), RATE_MAX)) : edge_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: enable alone moves between IDLE and COUNT.
    always_comb begin
        state_d = state;
        busy_d  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == COUNT);
    end

    // Edge history, window counter, edge counter and rate latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q    <= 1'b0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            spike_q    <= spike_in;
            busy       <= busy_d;
            rate_valid <= 1'b0;
            if (count_active_c) begin
                win_cnt <= win_cnt + WIN_ONE;
                if (win_cnt == WIN_LAST) begin
                    rate       <= edge_cnt_inc_c;
                    rate_valid <= 1'b1;
                    edge_cnt   <= '0;
                end else begin
                    edge_cnt <= edge_cnt_inc_c;
                end
            end else begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end
        end
    end

    isi_timer #(
        .ISI_W(ISI_W)
    ) u_isi_timer (
        .clk         (clk),
        .rst         (rst),
        .active      (count_active_c),
        .spike_edge  (edge_c),
        .isi         (isi),
        .isi_valid   (isi_valid),
        .isi_overflow(isi_overflow)
    );

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder using three parameterisations.
module tb_spike_rate_decoder;

    logic clk;
    logic rst;

    logic        en_a, spike_a;
    logic [7:0]  rate_a;
    logic        rv_a;
    logic [15:0] isi_a;
    logic        iv_a, ov_a, busy_a;

    logic        en_b, spike_b;
    logic [7:0]  rate_b;
    logic        rv_b;
    logic [15:0] isi_b;
    logic        iv_b, ov_b, busy_b;

    logic        en_c, spike_c;
    logic [7:0]  rate_c;
    logic        rv_c;
    logic [3:0]  isi_c;
    logic        iv_c, ov_c, busy_c;

    int checks = 0;
    int errors = 0;

    spike_rate_decoder #(.WINDOW_LOG2(4), .RATE_W(8), .ISI_W(16)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .spike_in(spike_a),
        .rate(rate_a), .rate_valid(rv_a), .isi(isi_a), .isi_valid(iv_a),
        .isi_overflow(ov_a), .busy(busy_a)
    );

    spike_rate_decoder #(.WINDOW_LOG2(10), .RATE_W(8), .ISI_W(16)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .spike_in(spike_b),
        .rate(rate_b), .rate_valid(rv_b), .isi(isi_b), .isi_valid(iv_b),
        .isi_overflow(ov_b), .busy(busy_b)
    );

    spike_rate_decoder #(.WINDOW_LOG2(4), .RATE_W(8), .ISI_W(4)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .spike_in(spike_c),
        .rate(rate_c), .rate_valid(rv_c), .isi(isi_c), .isi_valid(iv_c),
        .isi_overflow(ov_c), .busy(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_rate"},  32'(rate_a), 32'd0);
        check({tag, "_rv"},    32'(rv_a),   32'd0);
        check({tag, "_isi"},   32'(isi_a),  32'd0);
        check({tag, "_iv"},    32'(iv_a),   32'd0);
        check({tag, "_ov"},    32'(ov_a),   32'd0);
        check({tag, "_busy"},  32'(busy_a), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; spike_a = 1'b0;
        en_b = 1'b0; spike_b = 1'b0;
        en_c = 1'b0; spike_c = 1'b0;
        tick();
        tick();
        check_a_zero("reset");
        check("reset_c_ov", 32'(ov_c), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy_a), 32'd0);

        // Spikes every 4 cycles for three windows, then a 10-cycle high level.
        en_a = 1'b1;
        tick();
        check("enter_busy", 32'(busy_a), 32'd1);
        for (int c = 0; c < 64; c++) begin
            spike_a = (c < 48) ? (c % 4 == 0) : (c < 58);
            tick();
            check($sformatf("t1_rv_c%0d", c), 32'(rv_a), 32'((c % 16) == 15));
            if ((c % 16) == 15) begin
                check($sformatf("t1_rate_c%0d", c), 32'(rate_a), (c < 48) ? 32'd4 : 32'd1);
                check($sformatf("t1_busy_c%0d", c), 32'(busy_a), 32'd1);
            end
            if (c == 47) begin
                check("t1_isi4", 32'(isi_a), 32'd4);
            end
        end

        // Three edges, then drop enable mid-window.
        for (int c = 64; c < 70; c++) begin
            spike_a = (c == 64) || (c == 66) || (c == 68);
            tick();
            check($sformatf("t6_rv_c%0d", c), 32'(rv_a), 32'd0);
        end
        check("t6_isi_pre", 32'(isi_a), 32'd2);
        en_a = 1'b0;
        spike_a = 1'b0;
        tick();
        check("drop_busy", 32'(busy_a), 32'd0);
        check("drop_rv",   32'(rv_a),   32'd0);
        check("drop_rate", 32'(rate_a), 32'd1);
        check("drop_isi",  32'(isi_a),  32'd2);
        check("drop_iv",   32'(iv_a),   32'd0);
        spike_a = 1'b1;
        tick();
        tick();
        check("idle_rv", 32'(rv_a), 32'd0);
        en_a = 1'b1;
        tick();
        check("reenable_busy", 32'(busy_a), 32'd1);

        // Spike still high from IDLE: no edge at k=0. Edges at 5, 25, 28, 31, 33.
        for (int k = 0; k < 36; k++) begin
            spike_a = (k == 0) || (k == 5) || (k == 25) || (k == 28) || (k == 31) || (k == 33);
            tick();
            check($sformatf("t4_rv_k%0d", k), 32'(rv_a), 32'((k % 16) == 15));
            case (k)
                5: begin
                    check("t4_arm_iv",  32'(iv_a),  32'd0);
                    check("t4_arm_isi", 32'(isi_a), 32'd2);
                end
                15: check("t4_rate_w0", 32'(rate_a), 32'd1);
                25: begin
                    check("t4_iv25",  32'(iv_a),  32'd1);
                    check("t4_isi20", 32'(isi_a), 32'd20);
                end
                26: check("t4_iv_pulse", 32'(iv_a), 32'd0);
                28: begin
                    check("t4_iv28", 32'(iv_a),  32'd1);
                    check("t4_isi3", 32'(isi_a), 32'd3);
                end
                31: begin
                    check("t4_rate_last_edge", 32'(rate_a), 32'd3);
                    check("t4_sim_iv",         32'(iv_a),   32'd1);
                    check("t4_sim_isi",        32'(isi_a),  32'd3);
                end
                default: ;
            endcase
        end

        // Reset mid-window.
        rst = 1'b1;
        spike_a = 1'b0;
        tick();
        check_a_zero("midrst");
        rst = 1'b0;
        en_a = 1'b0;
        tick();

        // Toggle every cycle over a 1024-cycle window: 512 edges saturate at 255.
        en_b = 1'b1;
        tick();
        for (int c = 0; c < 1024; c++) begin
            spike_b = (c % 2 == 0);
            tick();
            if (c == 1022) check("sat_rv_early", 32'(rv_b), 32'd0);
            if (c == 1023) begin
                check("sat_rv",   32'(rv_b),   32'd1);
                check("sat_rate", 32'(rate_b), 32'd255);
                check("sat_isi",  32'(isi_b),  32'd2);
            end
        end
        en_b = 1'b0;
        spike_b = 1'b0;
        tick();

        // 4-bit ISI timer: a 40-cycle gap saturates and sets the sticky overflow.
        en_c = 1'b1;
        tick();
        for (int c = 0; c < 46; c++) begin
            spike_c = (c == 0) || (c == 40) || (c == 43);
            tick();
            case (c)
                0:  check("ov_arm_iv", 32'(iv_c), 32'd0);
                39: check("ov_pre",    32'(ov_c), 32'd0);
                40: begin
                    check("ov_iv",  32'(iv_c),  32'd1);
                    check("ov_isi", 32'(isi_c), 32'd15);
                    check("ov_set", 32'(ov_c),  32'd1);
                end
                43: begin
                    check("ov_iv2",    32'(iv_c),  32'd1);
                    check("ov_isi3",   32'(isi_c), 32'd3);
                    check("ov_sticky", 32'(ov_c),  32'd1);
                end
                45: check("ov_sticky2", 32'(ov_c), 32'd1);
                default: ;
            endcase
        end
        rst = 1'b1;
        spike_c = 1'b0;
        tick();
        check("ov_rst", 32'(ov_c), 32'd0);
        rst = 1'b0;
        en_c = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
